// File: rtl/seg7_scan_reader_pkg.sv
// Shared seven-segment definitions: segment bit order and the hex glyph set.
// The hex display driver and the scan reader both take their encoding from here.
package seg7_scan_reader_pkg;

   // Pattern vector P = {A,B,C,D,E,F,G}, active-low, A is the MSB.
   localparam int unsigned SEG_A = 6;
   localparam int unsigned SEG_B = 5;
   localparam int unsigned SEG_C = 4;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 2;
   localparam int unsigned SEG_F = 1;
   localparam int unsigned SEG_G = 0;

   localparam logic [6:0] GLYPH_0 = 7'h01;
   localparam logic [6:0] GLYPH_1 = 7'h4F;
   localparam logic [6:0] GLYPH_2 = 7'h12;
   localparam logic [6:0] GLYPH_3 = 7'h06;
   localparam logic [6:0] GLYPH_4 = 7'h4C;
   localparam logic [6:0] GLYPH_5 = 7'h24;
   localparam logic [6:0] GLYPH_6 = 7'h20;
   localparam logic [6:0] GLYPH_7 = 7'h0F;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h04;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_B = 7'h60;
   localparam logic [6:0] GLYPH_C = 7'h31;
   localparam logic [6:0] GLYPH_D = 7'h42;
   localparam logic [6:0] GLYPH_E = 7'h30;
   localparam logic [6:0] GLYPH_F = 7'h38;
   localparam logic [6:0] PAT_BLANK = 7'h7F;

   // Digit index of an active-low anode vector; only meaningful when exactly one bit is low.
   function automatic logic [1:0] sel_index(input logic [3:0] an_n);
      logic [1:0] idx;
      idx = 2'd0;
      if (!an_n[3]) begin
         idx = 2'd3;
      end else if (!an_n[2]) begin
         idx = 2'd2;
      end else if (!an_n[1]) begin
         idx = 2'd1;
      end
      return idx;
   endfunction

endpackage

// File: rtl/seg7_scan_reader_if.sv
// Display-bus bundle: anode/segment lines toward the reader, decoded frame back out.
interface seg7_scan_reader_if;

   logic [3:0]  An;
   logic        A;
   logic        B;
   logic        C;
   logic        D;
   logic        E;
   logic        F;
   logic        G;
   logic [15:0] Value;
   logic        Valid;
   logic        Err;
   logic        Stale;

   // master drives the display lines; slave is the reader that decodes them
   modport master (
      output An, A, B, C, D, E, F, G,
      input  Value, Valid, Err, Stale
   );

   modport slave (
      input  An, A, B, C, D, E, F, G,
      output Value, Valid, Err, Stale
   );

endinterface

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the hex glyph table: pattern to nibble, non-glyphs flagged.
module seg7_glyph_decode
   import seg7_scan_reader_pkg::*;
(
   input  logic [6:0] i_pat,
   output logic [3:0] o_nibble,
   output logic       o_invalid
);

   always_comb begin
      o_nibble  = 4'h0;
      o_invalid = 1'b0;
      case (i_pat)
         GLYPH_0: o_nibble = 4'h0;
         GLYPH_1: o_nibble = 4'h1;
         GLYPH_2: o_nibble = 4'h2;
         GLYPH_3: o_nibble = 4'h3;
         GLYPH_4: o_nibble = 4'h4;
         GLYPH_5: o_nibble = 4'h5;
         GLYPH_6: o_nibble = 4'h6;
         GLYPH_7: o_nibble = 4'h7;
         GLYPH_8: o_nibble = 4'h8;
         GLYPH_9: o_nibble = 4'h9;
         GLYPH_A: o_nibble = 4'hA;
         GLYPH_B: o_nibble = 4'hB;
         GLYPH_C: o_nibble = 4'hC;
         GLYPH_D: o_nibble = 4'hD;
         GLYPH_E: o_nibble = 4'hE;
         GLYPH_F: o_nibble = 4'hF;
         default: o_invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_scan_reader.sv
// Multiplexed 4-digit seven-segment bus reader: settles each digit, decodes it,
// and publishes a 16-bit frame once all four digits have been captured.
module seg7_scan_reader
   import seg7_scan_reader_pkg::*;
#(
   parameter int unsigned SETTLE  = 4,
   parameter int unsigned TIMEOUT = 1048576,
   parameter int unsigned CW      = 21
) (
   input  logic               clk,
   input  logic               reset,
   seg7_scan_reader_if.slave  bus
);

   localparam int unsigned SW = $clog2(SETTLE + 1);
   localparam logic [SW-1:0] SETTLE_C  = SW'(SETTLE);
   localparam logic [SW-1:0] SETTLE_M1 = SW'(SETTLE - 1);
   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

   logic [10:0]   w_raw;
   logic [10:0]   r_sync1;
   logic [10:0]   r_sync2;
   logic [10:0]   r_prev;
   logic [SW-1:0] r_cnt;
   logic [3:0]    r_seen;
   logic [3:0]    r_bad;
   logic [3:0]    w_seen_d;
   logic [3:0]    w_bad_d;
   logic [3:0]    r_slot [4];
   logic [15:0]   r_value;
   logic          r_valid;
   logic          r_err;
   logic [CW-1:0] r_tcnt;

   logic [3:0]    w_an;
   logic [6:0]    w_pat;
   logic          w_stable;
   logic          w_cap;
   logic          w_done;
   logic [1:0]    w_idx;
   logic [3:0]    w_nib;
   logic          w_inv;

   always_comb begin
      w_raw         = '0;
      w_raw[10:7]   = bus.An;
      w_raw[SEG_A]  = bus.A;
      w_raw[SEG_B]  = bus.B;
      w_raw[SEG_C]  = bus.C;
      w_raw[SEG_D]  = bus.D;
      w_raw[SEG_E]  = bus.E;
      w_raw[SEG_F]  = bus.F;
      w_raw[SEG_G]  = bus.G;
   end

   assign w_an     = r_sync2[10:7];
   assign w_pat    = r_sync2[6:0];
   assign w_stable = (r_sync2 == r_prev) && $onehot(~w_an);
   // Fires only on the transition into SETTLE, so one capture per dwell.
   assign w_cap    = w_stable && (r_cnt == SETTLE_M1);
   assign w_done   = (r_seen == 4'hF);
   assign w_idx    = sel_index(w_an);

   seg7_glyph_decode u_decode (
      .i_pat     (w_pat),
      .o_nibble  (w_nib),
      .o_invalid (w_inv)
   );

   // Frame clear first, then any same-cycle capture lands in the next frame.
   always_comb begin
      w_seen_d = w_done ? 4'h0 : r_seen;
      w_bad_d  = w_done ? 4'h0 : r_bad;
      if (w_cap) begin
         w_seen_d[w_idx] = 1'b1;
         w_bad_d[w_idx]  = w_inv;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
         r_cnt   <= '0;
         r_seen  <= '0;
         r_bad   <= '0;
         for (int i = 0; i < 4; i++) begin
            r_slot[i] <= '0;
         end
         r_value <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_tcnt  <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         if (!w_stable) begin
            r_cnt <= '0;
         end else if (r_cnt != SETTLE_C) begin
            r_cnt <= r_cnt + 1'b1;
         end
         r_seen <= w_seen_d;
         r_bad  <= w_bad_d;
         if (w_cap) begin
            r_slot[w_idx] <= w_nib;
         end
         r_valid <= w_done;
         if (w_done) begin
            r_value <= {r_slot[3], r_slot[2], r_slot[1], r_slot[0]};
            r_err   <= |r_bad;
            r_tcnt  <= '0;
         end else if (r_tcnt != TIMEOUT_C) begin
            r_tcnt <= r_tcnt + 1'b1;
         end
      end
   end

   assign bus.Value = r_value;
   assign bus.Valid = r_valid;
   assign bus.Err   = r_err;
   assign bus.Stale = (r_tcnt == TIMEOUT_C);

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader: scans hand-built frames and checks decoded results.
module tb_seg7_scan_reader;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_valid = 0;
   int   base = 0;
   bit   found = 1'b0;

   seg7_scan_reader_if bus ();

   seg7_scan_reader #(
      .SETTLE  (4),
      .TIMEOUT (100),
      .CW      (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.Valid === 1'b1) begin
         n_valid <= n_valid + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] an, input logic [6:0] p);
      bus.An = an;
      {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G} = p;
   endtask

   task automatic show(input logic [3:0] an, input logic [6:0] p, input int dwell);
      drive(an, p);
      repeat (dwell) tick();
   endtask

   // Scans digits 3..0 (patterns packed MSB first), then blanks long enough for Valid.
   task automatic frame(input logic [27:0] pats, input int dwell);
      show(4'b0111, pats[27:21], dwell);
      show(4'b1011, pats[20:14], dwell);
      show(4'b1101, pats[13:7], dwell);
      show(4'b1110, pats[6:0], dwell);
      show(4'b1111, 7'h7F, 6);
   endtask

   initial begin
      drive(4'b1111, 7'h7F);
      repeat (3) tick();
      chk("reset_value", bus.Value, 32'h0);
      chk("reset_valid", bus.Valid, 32'h0);
      chk("reset_err", bus.Err, 32'h0);
      chk("reset_stale", bus.Stale, 32'h0);
      reset = 1'b0;

      // idle timeout: Stale rises exactly at cycle 100
      repeat (99) tick();
      chk("stale_at_99", bus.Stale, 32'h0);
      tick();
      chk("stale_at_100", bus.Stale, 32'h1);

      // "1234", Valid clears Stale in the same cycle
      show(4'b0111, 7'h4F, 8);
      show(4'b1011, 7'h12, 8);
      show(4'b1101, 7'h06, 8);
      drive(4'b1110, 7'h4C);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (bus.Valid === 1'b1) found = 1'b1;
      end
      chk("1234_valid_seen", 32'(found), 32'h1);
      chk("1234_stale_with_valid", bus.Stale, 32'h0);
      chk("1234_value", bus.Value, 32'h1234);
      chk("1234_err", bus.Err, 32'h0);
      show(4'b1111, 7'h7F, 6);
      chk("1234_one_valid", n_valid, 32'd1);

      // "ABCD" with too-short dwell, then adequate dwell
      base = n_valid;
      frame({7'h08, 7'h60, 7'h31, 7'h42}, 3);
      chk("abcd_short_no_valid", n_valid - base, 32'd0);
      chk("abcd_short_value_held", bus.Value, 32'h1234);
      base = n_valid;
      frame({7'h08, 7'h60, 7'h31, 7'h42}, 6);
      chk("abcd_valid_count", n_valid - base, 32'd1);
      chk("abcd_value", bus.Value, 32'hABCD);
      chk("abcd_err", bus.Err, 32'h0);

      // blank digit 2 gives nibble 0 and Err
      base = n_valid;
      frame({7'h4F, 7'h7F, 7'h06, 7'h4C}, 8);
      chk("blank_valid_count", n_valid - base, 32'd1);
      chk("blank_value", bus.Value, 32'h1034);
      chk("blank_err", bus.Err, 32'h1);
      frame({7'h4F, 7'h12, 7'h06, 7'h4C}, 8);
      chk("clean_value", bus.Value, 32'h1234);
      chk("clean_err", bus.Err, 32'h0);

      // two anodes low never captures; glitch mid-dwell restarts settling
      base = n_valid;
      show(4'b0011, 7'h4F, 20);
      show(4'b0111, 7'h04, 4);
      show(4'b1111, 7'h7F, 1);
      show(4'b0111, 7'h04, 4);
      show(4'b1011, 7'h20, 8);
      show(4'b1101, 7'h0F, 8);
      show(4'b1110, 7'h00, 8);
      show(4'b1111, 7'h7F, 6);
      chk("glitch_no_valid", n_valid - base, 32'd0);
      show(4'b0111, 7'h24, 8);
      show(4'b1111, 7'h7F, 6);
      chk("glitch_then_valid", n_valid - base, 32'd1);
      chk("glitch_value", bus.Value, 32'h5678);

      // remaining glyphs 0, 9, E
      frame({7'h04, 7'h01, 7'h30, 7'h01}, 8);
      chk("90e0_value", bus.Value, 32'h90E0);
      chk("90e0_err", bus.Err, 32'h0);

      // reset mid-frame discards partial captures
      show(4'b0111, 7'h4F, 8);
      show(4'b1011, 7'h12, 8);
      show(4'b1101, 7'h06, 8);
      reset = 1'b1;
      repeat (2) tick();
      chk("midreset_value", bus.Value, 32'h0);
      chk("midreset_valid", bus.Valid, 32'h0);
      chk("midreset_err", bus.Err, 32'h0);
      chk("midreset_stale", bus.Stale, 32'h0);
      reset = 1'b0;
      base = n_valid;
      frame({7'h38, 7'h38, 7'h38, 7'h38}, 8);
      chk("ffff_valid_count", n_valid - base, 32'd1);
      chk("ffff_value", bus.Value, 32'hFFFF);
      chk("ffff_err", bus.Err, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
